// File: rtl/ex_muldiv_pkg.sv
// Shared op codes and state encoding for the EX-stage
// multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier and restoring divider registers,
// one bit per step; both run on the same magnitudes.
module muldiv_datapath #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quo,
  output logic [W-1:0]   rem
);

  logic [2*W-1:0] acc;
  logic [W-1:0]   mcand;
  logic [W-1:0]   dvs;
  logic [W-1:0]   quo_r;
  logic [W-1:0]   rem_r;
  logic [W:0]     psum;
  logic [W:0]     shifted;
  logic [W:0]     diff;

  assign psum = {1'b0, acc[2*W-1:W]}
              + {1'b0, (acc[0] ? mcand : '0)};
  // 33-bit partial remainder and its trial subtraction
  assign shifted = {rem_r, quo_r[W-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      dvs   <= '0;
      quo_r <= '0;
      rem_r <= '0;
    end else if (load) begin
      acc   <= {{W{1'b0}}, b};
      mcand <= a;
      dvs   <= b;
      quo_r <= a;
      rem_r <= '0;
    end else if (step) begin
      acc <= {psum, acc[W-1:1]};
      if (!diff[W]) begin
        rem_r <= diff[W-1:0];
        quo_r <= {quo_r[W-2:0], 1'b1};
      end else begin
        rem_r <= shifted[W-1:0];
        quo_r <= {quo_r[W-2:0], 1'b0};
      end
    end
  end

  assign prod = acc;
  assign quo  = quo_r;
  assign rem  = rem_r;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/DIV unit owning HI/LO,
// with pipeline stall on HI/LO hazards.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_value,
  input  logic [DATA_W-1:0] rt_value,
  input  logic              use_hilo,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  md_state_t           state;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                neg_res;
  logic                neg_rem;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic                is_sgn;
  logic                load;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign is_sgn = (op == MD_MULT) || (op == MD_DIV);
  assign load   = start && (state == MD_IDLE) && !op[2];

  assign a_mag = (is_sgn && rs_value[DATA_W-1])
               ? -rs_value : rs_value;
  assign b_mag = (is_sgn && rt_value[DATA_W-1])
               ? -rt_value : rt_value;

  muldiv_datapath #(.W(DATA_W)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (state == MD_RUN),
    .a    (a_mag),
    .b    (b_mag),
    .prod (prod),
    .quo  (quo),
    .rem  (rem)
  );

  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -quo  : quo;
  assign rem_fix  = neg_rem ? -rem  : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (start) begin
            unique case (op)
              MD_MTHI: hi <= rs_value;
              MD_MTLO: lo <= rs_value;
              MD_MULT, MD_MULTU,
              MD_DIV, MD_DIVU: begin
                is_div  <= op[1];
                neg_res <= is_sgn &
                  (rs_value[DATA_W-1] ^ rt_value[DATA_W-1]);
                neg_rem <= is_sgn & rs_value[DATA_W-1];
                cnt     <= '0;
                state   <= MD_RUN;
              end
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1))
            state <= MD_FIX;
        end
        MD_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*DATA_W-1:DATA_W];
            lo <= prod_fix[DATA_W-1:0];
          end
          done  <= 1'b1;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy   = (state != MD_IDLE);
  assign stall  = busy & use_hilo;
  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage of the mips32 pipeline, owning the HI/LO registers.
- Consumes the ID_EX register outputs: decoded muldiv op, rsValue and rtValue.
- Runs MULT/MULTU/DIV/DIVU over 32 iterations; executes MTHI/MTLO in one cycle.
- Raises a combinational stall back to PC/IF_ID/ID_EX when a later instruction needs HI/LO or the unit while it is busy.

Parameters:
- DATA_W, 32, operand and HI/LO width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  EX holds a muldiv/MTHI/MTLO instruction this cycle (from ID_EX control).
- op  input  3  operation code; values defined in parameters.v.
- rs_value  input  DATA_W  rs operand; dividend/multiplicand; MTHI/MTLO source.
- rt_value  input  DATA_W  rt operand; divisor/multiplier.
- use_hilo  input  1  ID stage holds MFHI/MFLO/MTHI/MTLO/MULT*/DIV*.
- busy  output  1  iteration in progress.
- stall  output  1  busy & use_hilo (combinational).
- done  output  1  one-cycle pulse after HI/LO are updated by a mul/div.
- hi_out  output  DATA_W  HI register.
- lo_out  output  DATA_W  LO register.

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE, HI=0, LO=0, counter=0, busy=0, done=0, internal accumulators=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start sampled at edge E0; start is ignored unless state=IDLE.
  - MTHI: HI<=rs_value at E0, stays IDLE.
  - MTLO: LO<=rs_value at E0, stays IDLE.
  - MULT/MULTU/DIV/DIVU: latch operands and sign info, counter<=0, go to RUN.
  - Unlisted op codes: no-op.
- Operand conditioning:
  - Signed ops (MULT, DIV) take magnitudes of both operands.
  - Record result sign = sign(rs) XOR sign(rt) and remainder sign = sign(rs).
- RUN, one iteration per edge E1..E32; counter increments; leave after count reaches 31.
  - Multiply: shift-add on a 64-bit accumulator, LSB-first multiplier.
  - Divide: restoring division, 1 quotient bit per cycle, 33-bit partial remainder.
- FIX (edge E33):
  - Apply sign correction by two's-complement negation.
  - Write HI/LO: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
  - Return to IDLE.
- Outputs:
  - busy=1 from after E0 through the cycle ending at E33.
  - done=1 for exactly the cycle after E33.
  - Accept-to-HI/LO latency is 33 cycles; a new start is accepted at E34 at the earliest.
  - hi_out/lo_out are direct register outputs; they hold their old values during RUN.
- Divide by zero, decided result:
  - LO=all ones, HI=rs_value (unsigned magnitude path, then sign fixup applies for DIV).
  - This falls out of restoring division; no special-case logic.
  - Takes the same 33 cycles.
- Signed overflow, DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- stall: asserted combinationally whenever busy & use_hilo; deasserted in the done cycle, so MFHI reads the new value.
- Pipeline responsibility: upstream guarantees start only follows a non-stalled ID->EX transfer; start while busy therefore never occurs in legal operation and is ignored.

Decomposition:
- parameters.v, as `define constants:
  - MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - State encodings MD_IDLE=2'd0, MD_RUN=2'd1, MD_FIX=2'd2.
- One natural sub-module, muldiv_datapath: accumulator/partial-remainder registers and the per-iteration add/subtract step.
- ex_muldiv keeps the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) -> busy 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulses once.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x1234, rt=0 -> LO=0xFFFFFFFF, HI=0x1234.
- MTHI rs=0xAAAA0000 while idle -> HI updated next edge, busy stays 0.
- Stall and reset:
  - Hold use_hilo=1 during a MULT -> stall=1 every busy cycle, stall=0 in the done cycle.
  - Assert rst at cycle 10 of a DIV -> busy=0, HI=LO=0 immediately, no done pulse.
